// File: rtl/memory_stage.sv
// Memory stage: up to two sequential load/store transfers on a single req/ack bus, then results to writeback.
// Latency: q_valid 1 cycle after accept with no bus work, else 1 cycle after the last ack; execute stalls meanwhile.
module memory_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic        cres,
  input  logic [31:0] m_a1,
  input  logic [31:0] m_a2,
  input  logic [3:0]  m_r1_op,
  input  logic [3:0]  m_r2_op,
  input  logic [4:0]  r_a1,
  input  logic [4:0]  r_a2,
  input  logic [3:0]  r_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] q1,
  output logic [31:0] q2,
  output logic [4:0]  qr_a1,
  output logic [4:0]  qr_a2,
  output logic [3:0]  qr_op,
  output logic        q_valid,
  output logic [1:0]  fault
);

  localparam logic [3:0] OP_LDW  = 4'b0001;
  localparam logic [3:0] OP_LDH  = 4'b0010;
  localparam logic [3:0] OP_LDB  = 4'b0011;
  localparam logic [3:0] OP_LDHS = 4'b0100;
  localparam logic [3:0] OP_LDBS = 4'b0101;
  localparam logic [3:0] OP_STW  = 4'b1001;
  localparam logic [3:0] OP_STH  = 4'b1010;
  localparam logic [3:0] OP_STB  = 4'b1011;

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, OUT} state_t;
  state_t state, state_nxt;

  function automatic logic is_ld(input logic [3:0] op);
    return (op == OP_LDW) || (op == OP_LDH) || (op == OP_LDB) ||
           (op == OP_LDHS) || (op == OP_LDBS);
  endfunction

  function automatic logic is_st(input logic [3:0] op);
    return (op == OP_STW) || (op == OP_STH) || (op == OP_STB);
  endfunction

  function automatic logic is_word(input logic [3:0] op);
    return (op == OP_LDW) || (op == OP_STW);
  endfunction

  function automatic logic is_half(input logic [3:0] op);
    return (op == OP_LDH) || (op == OP_LDHS) || (op == OP_STH);
  endfunction

  function automatic logic aligned(input logic [3:0] op, input logic [31:0] a);
    if (is_word(op)) return a[1:0] == 2'b00;
    if (is_half(op)) return !a[0];
    return 1'b1;
  endfunction

  function automatic logic slot_active(input logic c, input logic [3:0] op, input logic [31:0] a);
    return c && (is_ld(op) || is_st(op)) && aligned(op, a);
  endfunction

  function automatic logic slot_fault(input logic c, input logic [3:0] op, input logic [31:0] a);
    return c && (is_ld(op) || is_st(op)) && !aligned(op, a);
  endfunction

  function automatic logic [3:0] lane_be(input logic [3:0] op, input logic [31:0] a);
    if (is_word(op)) return 4'b1111;
    if (is_half(op)) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b0001 << a[1:0];
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
    if (op == OP_STB) return {4{d[7:0]}};
    if (op == OP_STH) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] load_value(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [15:0] h;
    logic [7:0]  b;
    h = a[1] ? rd[31:16] : rd[15:0];
    b = rd[8*a[1:0] +: 8];
    case (op)
      OP_LDW:  return rd;
      OP_LDH:  return {16'h0000, h};
      OP_LDHS: return {{16{h[15]}}, h};
      OP_LDB:  return {24'h000000, b};
      OP_LDBS: return {{24{b[7]}}, b};
      default: return 32'h0;
    endcase
  endfunction

  // Squash wins over misalignment; a misaligned slot reads as zero.
  function automatic logic [31:0] slot_q(input logic c, input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] r, input logic [31:0] rd);
    if (!c) return r;
    if (slot_fault(c, op, a)) return 32'h0;
    if (is_ld(op)) return load_value(op, a, rd);
    return r;
  endfunction

  // Latched copies of the accepted execute outputs
  logic [31:0] l_r1, l_r2, l_a1, l_a2, rd1, rd2;
  logic [3:0]  l_op1, l_op2, l_rop;
  logic [4:0]  l_ra1, l_ra2;
  logic        l_cres;

  // In IDLE the stage works on the live inputs so it can issue on the accept edge
  logic        idle, accept;
  logic [31:0] c_r1, c_r2, c_a1, c_a2, rd1_cur, rd2_cur;
  logic [3:0]  c_op1, c_op2, c_rop;
  logic [4:0]  c_ra1, c_ra2;
  logic        c_cres, act1, act2;

  assign idle    = (state == IDLE);
  assign accept  = idle && in_valid;
  assign c_r1    = idle ? r1      : l_r1;
  assign c_r2    = idle ? r2      : l_r2;
  assign c_a1    = idle ? m_a1    : l_a1;
  assign c_a2    = idle ? m_a2    : l_a2;
  assign c_op1   = idle ? m_r1_op : l_op1;
  assign c_op2   = idle ? m_r2_op : l_op2;
  assign c_rop   = idle ? r_op    : l_rop;
  assign c_ra1   = idle ? r_a1    : l_ra1;
  assign c_ra2   = idle ? r_a2    : l_ra2;
  assign c_cres  = idle ? cres    : l_cres;
  assign act1    = slot_active(c_cres, c_op1, c_a1);
  assign act2    = slot_active(c_cres, c_op2, c_a2);
  assign rd1_cur = (state == ACC1 && mem_ack) ? mem_rdata : rd1;
  assign rd2_cur = (state == ACC2 && mem_ack) ? mem_rdata : rd2;

  assign in_ready = idle;
  assign q_valid  = (state == OUT);

  logic        req_n, we_n;
  logic [31:0] addr_n, wdata_n;
  logic [3:0]  be_n;

  always_comb begin
    state_nxt = state;
    req_n     = mem_req;
    we_n      = mem_we;
    addr_n    = mem_addr;
    be_n      = mem_be;
    wdata_n   = mem_wdata;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (act1) begin
            state_nxt = ACC1;
            req_n     = 1'b1;
            we_n      = is_st(c_op1);
            addr_n    = {c_a1[31:2], 2'b00};
            be_n      = lane_be(c_op1, c_a1);
            wdata_n   = is_st(c_op1) ? store_data(c_op1, c_r1) : 32'h0;
          end else if (act2) begin
            state_nxt = ACC2;
            req_n     = 1'b1;
            we_n      = is_st(c_op2);
            addr_n    = {c_a2[31:2], 2'b00};
            be_n      = lane_be(c_op2, c_a2);
            wdata_n   = is_st(c_op2) ? store_data(c_op2, c_r2) : 32'h0;
          end else begin
            state_nxt = OUT;
          end
        end
      end
      ACC1: begin
        if (mem_ack) begin
          if (act2) begin
            state_nxt = ACC2;
            req_n     = 1'b1;
            we_n      = is_st(c_op2);
            addr_n    = {c_a2[31:2], 2'b00};
            be_n      = lane_be(c_op2, c_a2);
            wdata_n   = is_st(c_op2) ? store_data(c_op2, c_r2) : 32'h0;
          end else begin
            state_nxt = OUT;
            req_n     = 1'b0;
            we_n      = 1'b0;
            addr_n    = 32'h0;
            be_n      = 4'h0;
            wdata_n   = 32'h0;
          end
        end
      end
      ACC2: begin
        if (mem_ack) begin
          state_nxt = OUT;
          req_n     = 1'b0;
          we_n      = 1'b0;
          addr_n    = 32'h0;
          be_n      = 4'h0;
          wdata_n   = 32'h0;
        end
      end
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      state     <= state_nxt;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_be    <= be_n;
      mem_wdata <= wdata_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      l_r1 <= 32'h0; l_r2 <= 32'h0; l_a1 <= 32'h0; l_a2 <= 32'h0;
      l_op1 <= 4'h0; l_op2 <= 4'h0; l_rop <= 4'h0;
      l_ra1 <= 5'h0; l_ra2 <= 5'h0; l_cres <= 1'b0;
      rd1 <= 32'h0; rd2 <= 32'h0;
    end else begin
      if (accept) begin
        l_r1 <= r1; l_r2 <= r2; l_a1 <= m_a1; l_a2 <= m_a2;
        l_op1 <= m_r1_op; l_op2 <= m_r2_op; l_rop <= r_op;
        l_ra1 <= r_a1; l_ra2 <= r_a2; l_cres <= cres;
      end
      rd1 <= rd1_cur;
      rd2 <= rd2_cur;
    end
  end

  // Writeback outputs change only on entry to OUT and hold afterwards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1 <= 32'h0; q2 <= 32'h0;
      qr_a1 <= 5'h0; qr_a2 <= 5'h0; qr_op <= 4'h0; fault <= 2'b00;
    end else if (state_nxt == OUT) begin
      q1    <= slot_q(c_cres, c_op1, c_a1, c_r1, rd1_cur);
      q2    <= slot_q(c_cres, c_op2, c_a2, c_r2, rd2_cur);
      qr_a1 <= c_ra1;
      qr_a2 <= c_ra2;
      qr_op <= c_cres ? c_rop : 4'h0;
      fault <= {slot_fault(c_cres, c_op2, c_a2), slot_fault(c_cres, c_op1, c_a1)};
    end
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage after the execute stage of the CPU32 core. It consumes the registered execute results, the two memory-op slots and the register-writeback tags. It performs up to two sequential data-bus transactions (loads or stores) over a single-port req/ack bus. It then hands results and writeback tags to the writeback stage, stalling the execute stage while the bus is busy.

## Interface
Parameters: none (fixed 32-bit data/address).

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  execute-stage outputs valid this cycle
- in_ready  out  1  stage can accept; high only in IDLE
- r1, r2  in  32  execute results; store data for slot 1/2, passthrough value otherwise
- cres  in  1  condition result; 0 squashes both memory slots
- m_a1, m_a2  in  32  byte addresses, slot 1/2
- m_r1_op, m_r2_op  in  4  memory op, slot 1/2
- r_a1, r_a2  in  5  writeback register numbers
- r_op  in  4  writeback op, passed through untouched
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables, lane i = bits [8i+7:8i]
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  transfer complete this cycle
- q1, q2  out  32  slot results to writeback
- qr_a1, qr_a2  out  5  latched r_a1/r_a2
- qr_op  out  4  latched r_op; forced to 0 when squashed
- q_valid  out  1  one-cycle pulse, results valid
- fault  out  2  {slot2, slot1} misalignment, valid with q_valid

## Operation
- Op encoding:
  - 0000 none
  - 0001 LDW
  - 0010 LDH (zero-extend)
  - 0011 LDB (zero-extend)
  - 0100 LDHS (sign-extend)
  - 0101 LDBS (sign-extend)
  - 1001 STW
  - 1010 STH
  - 1011 STB
  - all others treated as none
- Accept on in_valid && in_ready; latch all inputs.
- A slot is active if cres=1, its op is a load/store, and it is aligned.
- Alignment: word needs addr[1:0]=00; half needs addr[0]=0; byte is always aligned.
- A misaligned slot sets its fault bit and makes no bus access; its q = 0.
- Byte lanes are little-endian:
  - word: be=1111
  - half: be=0011 if addr[1]=0, else 1100
  - byte: be=1<<addr[1:0]
- Store data: byte is replicated to all 4 lanes; half is replicated to both halves; word is passed as is.
- Loads: select lane(s) per addr, extend per op; q = extended value.
- Non-load slot (store, none, squashed): q = latched r input.
- Squash (cres=0): no bus access, fault=00, qr_op=0, q1/q2 = r1/r2.
- States:
  - IDLE: accept; go to ACC1 if slot1 active, else ACC2 if slot2 active, else OUT.
  - ACC1: mem_req=1 with slot1 controls. On mem_ack capture data, go to ACC2 if slot2 active, else OUT.
  - ACC2: same for slot2. On mem_ack go to OUT.
  - OUT: q_valid=1, go to IDLE.
- Slot 1 is always issued before slot 2.
- The writeback stage always accepts; there is no backpressure on q_valid.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0 except in_ready=1. mem_req drops immediately, even mid-transfer. An in-flight op is discarded and no q_valid is produced.
- mem_req/mem_we/mem_addr/mem_be/mem_wdata are registered and stable while mem_req=1 until mem_ack.
- mem_ack is ignored outside ACC1/ACC2.
- Accept at edge N:
  - No active slot: q_valid in cycle N+1.
  - Otherwise: mem_req rises in cycle N+1.
  - Zero-wait bus (ack in first req cycle): one slot → q_valid at N+2; two slots → q_valid at N+3.
- Back-to-back slots: mem_req stays high across ACC1→ACC2 and controls switch on the edge after the ack.
- in_ready=0 from the accept edge until the return to IDLE. Next accept is possible in the cycle after q_valid.
- q*/qr*/fault hold their values after q_valid until the next OUT.

## Test plan
- Passthrough: ops=0000, r1=0x11, r2=0x22, cres=1 → no mem_req; q_valid one cycle later; q1=0x11, q2=0x22, fault=00.
- LDBS slot1 at 0x1003, rdata=0x80FF_0000 → mem_addr=0x1000, be=1000, we=0; q1=0xFFFF_FF80.
- STH slot1 at 0x2002 with r1=0xABCD1234, then LDW slot2 at 0x3000 with ack after 3 waits:
  - first transfer: mem_wdata=0x1234_1234, be=1100, we=1, mem_req continuous;
  - then slot2 read; q_valid 1 cycle after the second ack.
- LDW at 0x4001 (slot1), LDH at 0x4006 (slot2) → one bus read, be=1100 at addr 0x4004; fault=01, q1=0.
- cres=0 with STW slot1 → no mem_req, qr_op=0, q1=r1.
- rst pulled low while ACC1 waiting for ack → mem_req=0 immediately; after release in_ready=1, no q_valid.
